redirect_cmd_issuer: RTL and testbench
======================================

// Module: redirect_cmd_issuer
// PURPOSE
// - Initiator-side generator of the redirect command sequence on one AXI W channel.
// - Per redirect request, emits two write-data beats: the ERROR_REDIRECT code beat,
//   then a target beat. On a stop request, emits one ERROR_REDIRECT_STOP beat.
// - Sits between a security/monitor controller and the AXI W channel of one target port.
//   The per-port redirect decoder on the crossbar side consumes this sequence.
// PARAMETERS
// - AXI_DATA_W     64                           W data width; must be >= 64.
// - LOG_N_INIT     2                            Width of the target initiator index.
// - REDIRECT_CODE  ariane_soc::ERROR_REDIRECT   Data word of the code beat.
// - STOP_CODE      ariane_soc::ERROR_REDIRECT_STOP  Data word of the stop beat.
// - TIMEOUT_CYC    1024                         ACTIVE cycles before auto-stop (REDIRECT_TIMEOUT_EN only).
// PORTS
// - clk_i         in   1           Clock; single clock domain.
// - rst_i         in   1           Reset; synchronous, active-high.
// - req_valid_i   in   1           Redirect request valid.
// - req_target_i  in   LOG_N_INIT  Redirect target index; sampled on handshake.
// - req_ready_o   out  1           Redirect request accepted.
// - stop_valid_i  in   1           Stop request valid.
// - stop_ready_o  out  1           Stop request accepted.
// - wdata_o       out  AXI_DATA_W  W channel data.
// - wvalid_o      out  1           W channel valid.
// - wlast_o       out  1           W channel last; equals wvalid_o (single-beat writes).
// - wready_i      in   1           W channel ready.
// - active_o      out  1           Redirect in force: target beat delivered, stop not yet delivered.
// BEHAVIOUR
// - Reset values: wvalid_o=0, wlast_o=0, wdata_o=0, active_o=0, FSM=IDLE, target reg=0, timeout counter=0.
// - In reset, wvalid_o drops at once, even mid-beat. This AXI hold-rule break is accepted.
// - FSM states:
//   - IDLE: req_ready_o=1.
//     - req handshake -> SEND_CODE; latch req_target_i.
//   - SEND_CODE: wvalid_o=1, wdata_o=REDIRECT_CODE.
//     - W handshake -> SEND_TGT.
//   - SEND_TGT: wvalid_o=1, wdata_o[63:32]=zero-extended target, all other bits 0.
//     - W handshake -> ACTIVE; active_o=1 from the next cycle.
//   - ACTIVE: stop_ready_o=1 and req_ready_o=1.
//     - stop handshake -> SEND_STOP.
//     - Otherwise, req handshake -> SEND_CODE (retarget). active_o stays 1 until a stop beat completes.
//     - If stop and req are both valid in the same cycle, stop wins and req_ready_o=0.
//   - SEND_STOP: wvalid_o=1, wdata_o=STOP_CODE.
//     - W handshake -> IDLE; active_o=0 from the next cycle.
// - Ready rules: req_ready_o=0 and stop_ready_o=0 in every SEND_* state.
// - stop_ready_o=0 in IDLE. A stop request in IDLE is held off, never dropped by the block.
// - All W outputs are registered.
//   - Request accepted at edge N -> code beat wvalid_o=1 from cycle N+1.
//   - Code handshake at edge M -> target beat valid at M+1. Beats run back-to-back, no bubble.
// - While wvalid_o=1 and wready_i=0, wdata_o and wlast_o hold stable (AXI rule).
// - There is no other handshake with wready_i.
// CONFIGURATION
// - Macro: REDIRECT_TIMEOUT_EN.
// - Defined:
//   - The counter clears on ACTIVE entry and on retarget.
//   - It increments each ACTIVE cycle.
//   - When it reaches TIMEOUT_CYC-1 with no stop/req handshake that cycle -> SEND_STOP.
//   - An external stop or req handshake in that same cycle takes precedence.
// - Not defined: no counter; ACTIVE is held until an external stop.
// TESTING
// - Basic redirect:
//   - Stimulus: req target=2, wready_i=1.
//   - Response: beats REDIRECT_CODE, then 64'h0000_0002_0000_0000 in consecutive cycles.
//   - active_o=1 one cycle after the second beat.
// - Backpressure:
//   - Stimulus: wready_i=0 for 5 cycles on each beat.
//   - Response: wdata_o/wvalid_o hold stable; exactly 2 handshakes; sequence unchanged.
// - Stop:
//   - Stimulus: from ACTIVE, stop_valid_i=1.
//   - Response: one STOP_CODE beat; active_o=0 after it.
//   - Stimulus: stop_valid_i held in IDLE.
//   - Response: stop_ready_o stays 0; no beat.
// - Simultaneous request and stop:
//   - Stimulus: in ACTIVE, req target=1 and stop in the same cycle.
//   - Response: stop_ready_o=1, req_ready_o=0, STOP_CODE beat.
//   - Then the held req is accepted from IDLE: code beat, then 64'h0000_0001_0000_0000.
// - Reset mid-beat:
//   - Stimulus: rst_i=1 during SEND_TGT with wready_i=0.
//   - Response: next cycle wvalid_o=0, active_o=0, req_ready_o=1.
// - Timeout (REDIRECT_TIMEOUT_EN, TIMEOUT_CYC=8):
//   - Stimulus: idle in ACTIVE.
//   - Response: STOP_CODE beat is valid on the 9th cycle after ACTIVE entry.

Source files
------------

// File: rtl/redirect_cmd_issuer.sv
// redirect_cmd_issuer
// Initiator-side generator of the redirect command sequence on one AXI W channel.
// A redirect request produces a code beat followed by a target beat; a stop
// request produces a single stop beat.
// Optional feature macro: REDIRECT_TIMEOUT_EN (auto-stop after TIMEOUT_CYC cycles
// in ACTIVE with no stop/request handshake).
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no redirect in force, waiting for a request
// SEND_CODE | presenting the REDIRECT_CODE beat
// SEND_TGT  | presenting the target beat (target index in bits [63:32])
// ACTIVE    | redirect in force, waiting for stop or retarget
// SEND_STOP | presenting the STOP_CODE beat
module redirect_cmd_issuer #(
    parameter int                    AXI_DATA_W    = 64,
    parameter int                    LOG_N_INIT    = 2,
    parameter logic [AXI_DATA_W-1:0] REDIRECT_CODE = AXI_DATA_W'(64'hE44E_D1E0_0000_0001),
    parameter logic [AXI_DATA_W-1:0] STOP_CODE     = AXI_DATA_W'(64'hE44E_D1E0_0000_0002),
    parameter int                    TIMEOUT_CYC   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [LOG_N_INIT-1:0] req_target_i,
    output logic                  req_ready_o,
    input  logic                  stop_valid_i,
    output logic                  stop_ready_o,
    output logic [AXI_DATA_W-1:0] wdata_o,
    output logic                  wvalid_o,
    output logic                  wlast_o,
    input  logic                  wready_i,
    output logic                  active_o
);

    // Elaboration guard on parameter ranges the beat layout depends on.
    if (AXI_DATA_W < 64 || LOG_N_INIT < 1 || LOG_N_INIT > 32 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("redirect_cmd_issuer: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_CODE,
        S_SEND_TGT,
        S_ACTIVE,
        S_SEND_STOP
    } state_t;

    state_t                state;
    logic [LOG_N_INIT-1:0] target_q;

    // Target beat: zero-extended index in the upper word, everything else zero.
    function automatic logic [AXI_DATA_W-1:0] target_word(input logic [LOG_N_INIT-1:0] t);
        logic [AXI_DATA_W-1:0] w;
        w = '0;
        w[32 +: LOG_N_INIT] = t;
        return w;
    endfunction

    // Stop has priority over a simultaneous request in ACTIVE, so the request is held off.
    assign req_ready_o  = (state == S_IDLE) || ((state == S_ACTIVE) && !stop_valid_i);
    assign stop_ready_o = (state == S_ACTIVE);
    assign wlast_o      = wvalid_o;

`ifdef REDIRECT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;
    assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    // Sequencer: state, latched target and all W-channel outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            target_q <= '0;
            wvalid_o <= 1'b0;
            wdata_o  <= '0;
            active_o <= 1'b0;
`ifdef REDIRECT_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        state    <= S_SEND_CODE;
                        target_q <= req_target_i;
                        wvalid_o <= 1'b1;
                        wdata_o  <= REDIRECT_CODE;
                    end
                end
                S_SEND_CODE: begin
                    if (wready_i) begin
                        state   <= S_SEND_TGT;
                        wdata_o <= target_word(target_q);
                    end
                end
                S_SEND_TGT: begin
                    if (wready_i) begin
                        state    <= S_ACTIVE;
                        wvalid_o <= 1'b0;
                        wdata_o  <= '0;
                        active_o <= 1'b1;
`ifdef REDIRECT_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                S_ACTIVE: begin
                    if (stop_valid_i) begin
                        state    <= S_SEND_STOP;
                        wvalid_o <= 1'b1;
                        wdata_o  <= STOP_CODE;
                    end else if (req_valid_i) begin
                        state    <= S_SEND_CODE;
                        target_q <= req_target_i;
                        wvalid_o <= 1'b1;
                        wdata_o  <= REDIRECT_CODE;
`ifdef REDIRECT_TIMEOUT_EN
                        to_cnt   <= '0;
                    end else if (to_hit) begin
                        state    <= S_SEND_STOP;
                        wvalid_o <= 1'b1;
                        wdata_o  <= STOP_CODE;
                    end else begin
                        to_cnt   <= to_cnt + 1'b1;
`endif
                    end
                end
                S_SEND_STOP: begin
                    if (wready_i) begin
                        state    <= S_IDLE;
                        wvalid_o <= 1'b0;
                        wdata_o  <= '0;
                        active_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wvalid_o <= 1'b0;
                    wdata_o  <= '0;
                    active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redirect_cmd_issuer.sv
// Testbench for redirect_cmd_issuer: directed scenarios plus randomized
// redirect/stop traffic under random W backpressure, checked by a beat scoreboard.
module tb_redirect_cmd_issuer;

    localparam int          DW   = 64;
    localparam int          LN   = 2;
    localparam int          TO   = 8;
    localparam logic [63:0] CODE = 64'hC0DE_0000_0000_00A1;
    localparam logic [63:0] STOP = 64'hC0DE_0000_0000_00F0;

    logic          clk;
    logic          rst_i;
    logic          req_valid_i;
    logic [LN-1:0] req_target_i;
    logic          req_ready_o;
    logic          stop_valid_i;
    logic          stop_ready_o;
    logic [DW-1:0] wdata_o;
    logic          wvalid_o;
    logic          wlast_o;
    logic          wready_i;
    logic          active_o;

    redirect_cmd_issuer #(
        .AXI_DATA_W   (DW),
        .LOG_N_INIT   (LN),
        .REDIRECT_CODE(CODE),
        .STOP_CODE    (STOP),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_target_i(req_target_i),
        .req_ready_o (req_ready_o),
        .stop_valid_i(stop_valid_i),
        .stop_ready_o(stop_ready_o),
        .wdata_o     (wdata_o),
        .wvalid_o    (wvalid_o),
        .wlast_o     (wlast_o),
        .wready_i    (wready_i),
        .active_o    (active_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_beats  = 0;
    logic [63:0] exp_q[$];
    bit          model_active = 0;
    bit          bp_manual    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [63:0] tword(input int t);
        return 64'(t) << 32;
    endfunction

    // Random W backpressure unless a directed test drives wready_i itself.
    initial begin
        wready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_manual) wready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every W handshake, checks AXI hold under stall.
    initial begin
        logic [63:0] prev_data;
        logic [63:0] e;
        bit          prev_stall;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_wvalid", wvalid_o, 1);
                    chk("hold_wdata", wdata_o, prev_data);
                end
                if (wvalid_o && wready_i) begin
                    n_beats++;
                    chk("wlast", wlast_o, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", wvalid_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", wdata_o, e);
                    end
                end
                prev_stall = wvalid_o && !wready_i;
                prev_data  = wdata_o;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit is_stop, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_stop ? stop_ready_o : req_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            if (is_stop) chk("stop_ready_timeout", stop_ready_o, 1);
            else         chk("req_ready_timeout", req_ready_o, 1);
        end
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_redirect(input int t);
        bit ok;
        req_valid_i  = 1'b1;
        req_target_i = LN'(t);
        wait_ready(0, ok);
        if (ok) begin
            exp_q.push_back(CODE);
            exp_q.push_back(tword(t));
        end
        step();
        req_valid_i = 1'b0;
        wait_drain();
        @(negedge clk);
        chk("active_after_redirect", active_o, 1);
        chk("idle_w_after_redirect", wvalid_o, 0);
        model_active = 1;
        step();
    endtask

    task automatic do_stop();
        bit ok;
        stop_valid_i = 1'b1;
        if (model_active) begin
            wait_ready(1, ok);
            if (ok) exp_q.push_back(STOP);
            step();
            stop_valid_i = 1'b0;
            wait_drain();
            @(negedge clk);
            chk("inactive_after_stop", active_o, 0);
            chk("idle_w_after_stop", wvalid_o, 0);
            model_active = 0;
            step();
        end else begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("stop_ready_in_idle", stop_ready_o, 0);
                chk("no_beat_in_idle", wvalid_o, 0);
            end
            step();
            stop_valid_i = 1'b0;
        end
    endtask

    task automatic do_simul();
        bit ok;
        if (!model_active) do_redirect(int'($urandom_range(0, 3)));
        req_valid_i  = 1'b1;
        req_target_i = 2'd1;
        stop_valid_i = 1'b1;
        @(negedge clk);
        chk("simul_stop_ready", stop_ready_o, 1);
        chk("simul_req_ready", req_ready_o, 0);
        exp_q.push_back(STOP);
        step();
        stop_valid_i = 1'b0;
        wait_ready(0, ok);
        if (ok) begin
            exp_q.push_back(CODE);
            exp_q.push_back(tword(1));
        end
        step();
        req_valid_i = 1'b0;
        wait_drain();
        @(negedge clk);
        chk("simul_active", active_o, 1);
        model_active = 1;
        step();
    endtask

    initial begin
        bit ok;
        int b0;
        int r;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_target_i = '0;
        stop_valid_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_wvalid", wvalid_o, 0);
        chk("rst_wlast", wlast_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_active", active_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_stop_ready", stop_ready_o, 0);
        step();
        rst_i = 1'b0;
        step();

        // Basic redirect with exact beat timing.
        bp_manual = 1;
        wready_i  = 1'b1;
        req_valid_i  = 1'b1;
        req_target_i = 2'd2;
        wait_ready(0, ok);
        if (ok) begin
            exp_q.push_back(CODE);
            exp_q.push_back(tword(2));
        end
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("basic_code_valid", wvalid_o, 1);
        chk("basic_code_data", wdata_o, CODE);
        @(negedge clk);
        chk("basic_tgt_valid", wvalid_o, 1);
        chk("basic_tgt_data", wdata_o, 64'h0000_0002_0000_0000);
        chk("basic_active_early", active_o, 0);
        @(negedge clk);
        chk("basic_active", active_o, 1);
        chk("basic_wvalid_low", wvalid_o, 0);
        model_active = 1;
        step();
        bp_manual = 0;

        // Stop from ACTIVE, then stop held in IDLE.
        do_stop();
        do_stop();

        // Backpressure: 5 stalled cycles on each beat.
        bp_manual   = 1;
        wready_i    = 1'b0;
        req_valid_i  = 1'b1;
        req_target_i = 2'd3;
        wait_ready(0, ok);
        if (ok) begin
            exp_q.push_back(CODE);
            exp_q.push_back(tword(3));
        end
        b0 = n_beats;
        step();
        req_valid_i = 1'b0;
        repeat (5) step();
        wready_i = 1'b1;
        step();
        wready_i = 1'b0;
        repeat (5) step();
        wready_i = 1'b1;
        step();
        wready_i = 1'b0;
        @(negedge clk);
        chk("bp_beat_count", 64'(n_beats - b0), 2);
        chk("bp_active", active_o, 1);
        chk("bp_queue_empty", 64'(exp_q.size()), 0);
        model_active = 1;
        step();
        bp_manual = 0;

        // Simultaneous request and stop from ACTIVE.
        do_simul();

        // Randomized traffic against the transaction-level model.
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      do_redirect(int'($urandom_range(0, 3)));
            else if (r < 8) do_stop();
            else if (r == 8) do_simul();
            else if (!model_active) repeat ($urandom_range(1, 3)) step();
        end

        // Reset while the target beat is stalled, starting from a retarget.
        if (!model_active) do_redirect(1);
        bp_manual    = 1;
        wready_i     = 1'b0;
        req_valid_i  = 1'b1;
        req_target_i = 2'd0;
        wait_ready(0, ok);
        if (ok) begin
            exp_q.push_back(CODE);
            exp_q.push_back(tword(0));
        end
        step();
        req_valid_i = 1'b0;
        wready_i    = 1'b1;
        step();
        wready_i = 1'b0;
        repeat (2) step();
        rst_i = 1'b1;
        step();
        @(negedge clk);
        chk("rstmid_wvalid", wvalid_o, 0);
        chk("rstmid_active", active_o, 0);
        chk("rstmid_req_ready", req_ready_o, 1);
        exp_q.delete();
        step();
        rst_i        = 1'b0;
        model_active = 0;
        step();

        // ACTIVE hold behaviour: auto-stop when enabled, otherwise held indefinitely.
        wready_i     = 1'b1;
        req_valid_i  = 1'b1;
        req_target_i = 2'd3;
        wait_ready(0, ok);
        if (ok) begin
            exp_q.push_back(CODE);
            exp_q.push_back(tword(3));
        end
        step();
        req_valid_i = 1'b0;
        repeat (2) step();
`ifdef REDIRECT_TIMEOUT_EN
        exp_q.push_back(STOP);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("to_quiet", wvalid_o, 0);
            chk("to_active", active_o, 1);
        end
        @(negedge clk);
        chk("to_stop_valid", wvalid_o, 1);
        chk("to_stop_data", wdata_o, STOP);
        step();
        @(negedge clk);
        chk("to_inactive", active_o, 0);
        model_active = 0;
`else
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("hold_quiet", wvalid_o, 0);
            chk("hold_active", active_o, 1);
        end
        model_active = 1;
`endif
        step();
        bp_manual = 0;
        if (model_active) do_stop();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
